// File: rtl/digit_downsampler.sv
// Crops a 28*BLK square window from a greyscale stream and stores a 28x28 grid of
// per-block ink counts (saturated to 8 bits), read back by the classifier after capture.
module digit_downsampler #(
    parameter int          IMG_W  = 640,
    parameter int          IMG_H  = 480,
    parameter int          CROP_X = 96,
    parameter int          CROP_Y = 16,
    parameter int          BLK    = 16,
    parameter logic [11:0] THRESH = 12'd1024
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSOF,
    input  logic [11:0] iDATA,
    input  logic        iDVAL,
    input  logic        iACK,
    input  logic [9:0]  iRD_ADDR,
    output logic [7:0]  oRD_DATA,
    output logic        oFRAME_RDY,
    output logic        oBUSY
);
    localparam int GRID  = 28;
    localparam int CELLS = GRID * GRID;
    localparam int WIN   = GRID * BLK;
    localparam int BW    = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int AW    = $clog2(BLK * BLK + 1);

    localparam logic [10:0]   X_LO   = 11'(CROP_X);
    localparam logic [10:0]   X_HI   = 11'(CROP_X + WIN);
    localparam logic [10:0]   X_LAST = 11'(IMG_W - 1);
    localparam logic [9:0]    Y_LO   = 10'(CROP_Y);
    localparam logic [9:0]    Y_HI   = 10'(CROP_Y + WIN);
    localparam logic [9:0]    Y_LAST = 10'(IMG_H - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLK - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [4:0]    G_LAST = 5'd27;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t          state_q;
    logic [10:0]     x_q;
    logic [9:0]      y_q;
    logic [BW-1:0]   bx_q;
    logic [BW-1:0]   by_q;
    logic [4:0]      col_q;
    logic [4:0]      row_q;
    logic [AW-1:0]   acc_q [0:GRID-1];
    logic            busy_q;
    logic            rdy_q;
    logic [7:0]      rd_data_q;
    logic [7:0]      ram_q [0:CELLS-1];

    logic            restart_s;
    logic            pix_s;
    logic [10:0]     px_x_s;
    logic [9:0]      px_y_s;
    logic [BW-1:0]   px_bx_s;
    logic [BW-1:0]   px_by_s;
    logic [4:0]      px_col_s;
    logic [4:0]      px_row_s;
    logic            in_x_s;
    logic            in_y_s;
    logic            ink_s;
    logic [AW-1:0]   acc_cur_s;
    logic            cell_wr_s;
    logic            last_cell_s;
    logic [9:0]      wr_addr_s;
    logic [7:0]      wr_data_s;

    function automatic logic [7:0] sat8(input logic [15:0] v);
        sat8 = (v > 16'd255) ? 8'd255 : v[7:0];
    endfunction

    // Position of the current pixel: a start-of-frame pulse makes it pixel (0,0) of a fresh frame
    always_comb begin
        restart_s   = iSOF && (state_q != ST_DONE);
        pix_s       = iDVAL && (restart_s || (state_q == ST_CAPTURE));
        px_x_s      = restart_s ? 11'd0 : x_q;
        px_y_s      = restart_s ? 10'd0 : y_q;
        px_bx_s     = restart_s ? {BW{1'b0}} : bx_q;
        px_by_s     = restart_s ? {BW{1'b0}} : by_q;
        px_col_s    = restart_s ? 5'd0 : col_q;
        px_row_s    = restart_s ? 5'd0 : row_q;
        in_x_s      = (px_x_s >= X_LO) && (px_x_s < X_HI);
        in_y_s      = (px_y_s >= Y_LO) && (px_y_s < Y_HI);
        ink_s       = (iDATA < THRESH);
        acc_cur_s   = restart_s ? {AW{1'b0}} : acc_q[px_col_s];
        cell_wr_s   = pix_s && in_x_s && in_y_s && (px_bx_s == B_LAST) && (px_by_s == B_LAST);
        last_cell_s = cell_wr_s && (px_row_s == G_LAST) && (px_col_s == G_LAST);
        wr_addr_s   = 10'(px_row_s) * 10'd28 + 10'(px_col_s);
        wr_data_s   = sat8(16'(acc_cur_s) + 16'(ink_s));
    end

    // Capture FSM, raster counters, block sub-counters and column accumulators
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_WAIT_SOF;
            x_q     <= 11'd0;
            y_q     <= 10'd0;
            bx_q    <= {BW{1'b0}};
            by_q    <= {BW{1'b0}};
            col_q   <= 5'd0;
            row_q   <= 5'd0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            for (int i = 0; i < GRID; i++) acc_q[i] <= {AW{1'b0}};
        end else begin
            if (restart_s) begin
                state_q <= ST_CAPTURE;
                busy_q  <= 1'b1;
                rdy_q   <= 1'b0;
                x_q     <= 11'd0;
                y_q     <= 10'd0;
                bx_q    <= {BW{1'b0}};
                by_q    <= {BW{1'b0}};
                col_q   <= 5'd0;
                row_q   <= 5'd0;
                for (int i = 0; i < GRID; i++) acc_q[i] <= {AW{1'b0}};
            end
            if (pix_s) begin
                if (px_x_s == X_LAST) begin
                    x_q   <= 11'd0;
                    bx_q  <= {BW{1'b0}};
                    col_q <= 5'd0;
                    y_q   <= (px_y_s == Y_LAST) ? px_y_s : px_y_s + 10'd1;
                    if (in_y_s && (px_by_s == B_LAST)) begin
                        by_q  <= {BW{1'b0}};
                        row_q <= (px_row_s == G_LAST) ? px_row_s : px_row_s + 5'd1;
                    end else if (in_y_s) begin
                        by_q  <= px_by_s + B_ONE;
                        row_q <= px_row_s;
                    end else begin
                        by_q  <= px_by_s;
                        row_q <= px_row_s;
                    end
                end else begin
                    x_q   <= px_x_s + 11'd1;
                    y_q   <= px_y_s;
                    by_q  <= px_by_s;
                    row_q <= px_row_s;
                    if (in_x_s && (px_bx_s == B_LAST)) begin
                        bx_q  <= {BW{1'b0}};
                        col_q <= (px_col_s == G_LAST) ? px_col_s : px_col_s + 5'd1;
                    end else if (in_x_s) begin
                        bx_q  <= px_bx_s + B_ONE;
                        col_q <= px_col_s;
                    end else begin
                        bx_q  <= px_bx_s;
                        col_q <= px_col_s;
                    end
                end
                // The block's final pixel empties the column so the next block row starts at zero
                if (in_x_s && in_y_s) begin
                    acc_q[px_col_s] <= cell_wr_s ? {AW{1'b0}} : acc_cur_s + AW'(ink_s);
                end
            end
            if (last_cell_s) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                rdy_q   <= 1'b1;
            end else if ((state_q == ST_DONE) && iACK) begin
                state_q <= ST_WAIT_SOF;
                rdy_q   <= 1'b0;
            end
        end
    end

    // Grid storage, written once per completed block
    always_ff @(posedge iCLK) begin
        if (cell_wr_s) begin
            ram_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered read port; addresses past the grid read as zero
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rd_data_q <= 8'd0;
        end else if (iRD_ADDR < 10'(CELLS)) begin
            rd_data_q <= ram_q[iRD_ADDR];
        end else begin
            rd_data_q <= 8'd0;
        end
    end

    assign oRD_DATA   = rd_data_q;
    assign oFRAME_RDY = rdy_q;
    assign oBUSY      = busy_q;

endmodule
